// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, opcode encodings and the
// fetch FSM state encoding used by instr_fetch and the controller.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 8;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    ISSUE  = 2'b01,
    EXEC   = 2'b10,
    HALTED = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: parallel load for jumps, increment with natural wrap
// at 2^ADDR_W. Load takes priority over increment.
module pc_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests program memory at pc, latches the
// instruction register, issues it to the controller and resolves HLT/JMP/SKZ.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ir_valid,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  input  logic              ctrl_done,
  input  logic              acc_zero,
  input  logic              resume,
  output logic              halted
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [DATA_W-1:0] ir;
  logic              fetch_armed;
  logic              ir_load;
  logic              pc_load;
  logic              pc_inc;

  // fetch_armed holds off the request for one cycle after reset release so
  // the first fetch starts on the first rising edge with rst_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_armed <= 1'b0;
      ir          <= '0;
    end else begin
      state       <= state_next;
      fetch_armed <= 1'b1;
      if (ir_load) begin
        ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    unique case (state)
      FETCH: begin
        if (mem_req && mem_ack) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (ctrl_done) begin
          state_next = FETCH;
          case (opcode)
            OP_HLT:  state_next = HALTED;
            OP_JMP:  pc_load = 1'b1;
            OP_SKZ:  pc_inc = acc_zero;
            default: ;
          endcase
        end
      end
      HALTED: begin
        if (resume) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign mem_req  = fetch_armed && (state == FETCH);
  assign mem_addr = pc;
  assign ir_valid = (state == ISSUE);
  assign halted   = (state == HALTED);
  assign opcode   = ir[DATA_W-1 -: 3];
  assign operand  = ir[ADDR_W-1:0];

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (operand),
    .inc      (pc_inc),
    .pc       (pc)
  );

endmodule
